design_07_result_drain: RTL and testbench

Downstream consumer for the 11-bit arithmetic design core. Waits until the core's result and check methods are both ready, then pops the check value and latches the result in the same cycle. Compares the two, keeps saturating match/mismatch counters and a sticky error flag, and buffers accepted results in a small FIFO. A later sink drains that FIFO through an EN/RDY dequeue method.

---
 rtl/design_07_result_drain.sv | 116 +++++++++++
 tb/tb_design_07_result_drain.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/design_07_result_drain.sv
// Result drain: takes result/check pairs from the arithmetic core, compares them and buffers results in a FIFO.
// Optional macro DESIGN_07_RESULT_DRAIN_HALT_ON_ERR_EN stops taking new pairs after the first mismatch.
module design_07_result_drain #(
  parameter int WIDTH = 11,
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] up_result,
  input  logic             RDY_up_result,
  input  logic [WIDTH-1:0] up_chresult,
  input  logic             RDY_up_check,
  output logic             EN_up_check,
  output logic [WIDTH-1:0] out_data,
  output logic             RDY_out,
  input  logic             EN_out,
  output logic [CNT_W-1:0] match_count,
  output logic [CNT_W-1:0] mismatch_count,
  output logic             err
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

`ifdef DESIGN_07_RESULT_DRAIN_HALT_ON_ERR_EN
  typedef enum logic [1:0] {IDLE, COMPARE, HALT} state_t;
`else
  typedef enum logic [1:0] {IDLE, COMPARE} state_t;
`endif

  state_t           state;
  logic [WIDTH-1:0] holdRes;
  logic [WIDTH-1:0] holdChk;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rdPtr;
  logic [PW-1:0]    wrPtr;
  logic [CW-1:0]    count;
  logic             full;
  logic             take;
  logic             push;
  logic             pop;

  // The full test uses the registered count, so a same-cycle pop never frees a slot for this take.
  assign full        = (count == FULL_CNT);
  assign take        = (state == IDLE) && RDY_up_result && RDY_up_check && !full;
  assign EN_up_check = take;
  assign push        = (state == COMPARE);
  assign RDY_out     = (count != '0);
  assign pop         = EN_out && RDY_out;
  assign out_data    = mem[rdPtr];

  always_ff @(posedge CLK) begin
    if (take) begin
      holdRes <= up_result;
      holdChk <= up_chresult;
    end
  end

  always_ff @(posedge CLK) begin
    if (push && !RST)
      mem[wrPtr] <= holdRes;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state          <= IDLE;
      match_count    <= '0;
      mismatch_count <= '0;
      err            <= 1'b0;
      rdPtr          <= '0;
      wrPtr          <= '0;
      count          <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (take)
            state <= COMPARE;
        end
        COMPARE: begin
          // Counters stick at all-ones instead of wrapping.
          if (holdRes == holdChk) begin
            if (match_count != '1)
              match_count <= match_count + CNT_W'(1);
          end else begin
            if (mismatch_count != '1)
              mismatch_count <= mismatch_count + CNT_W'(1);
            err <= 1'b1;
          end
`ifdef DESIGN_07_RESULT_DRAIN_HALT_ON_ERR_EN
          state <= (holdRes == holdChk) ? IDLE : HALT;
`else
          state <= IDLE;
`endif
        end
`ifdef DESIGN_07_RESULT_DRAIN_HALT_ON_ERR_EN
        HALT: state <= HALT;
`endif
        default: state <= IDLE;
      endcase

      if (push)
        wrPtr <= wrPtr + PW'(1);
      if (pop)
        rdPtr <= rdPtr + PW'(1);

      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_design_07_result_drain.sv
// Self-checking bench for design_07_result_drain: directed phases plus random traffic against a queue-based model.
module tb_design_07_result_drain;

  localparam int WIDTH = 11;
  localparam int DEPTH = 4;
  localparam int CNT_W = 8;

  logic             CLK = 1'b0;
  logic             RST;
  logic [WIDTH-1:0] up_result;
  logic             RDY_up_result;
  logic [WIDTH-1:0] up_chresult;
  logic             RDY_up_check;
  logic             EN_up_check;
  logic [WIDTH-1:0] out_data;
  logic             RDY_out;
  logic             EN_out;
  logic [CNT_W-1:0] match_count;
  logic [CNT_W-1:0] mismatch_count;
  logic             err;

  int checks = 0;
  int failures = 0;

  logic [WIDTH-1:0] fifoQ [$];
  int               mCnt;
  int               mmCnt;
  bit               errM;
  bit               pending;
  bit               halted;
  bit               lastTake;
  logic [WIDTH-1:0] pendRes;
  logic [WIDTH-1:0] pendChk;
  int               takes;

  always #5 CLK = ~CLK;

  design_07_result_drain #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .CLK(CLK),
    .RST(RST),
    .up_result(up_result),
    .RDY_up_result(RDY_up_result),
    .up_chresult(up_chresult),
    .RDY_up_check(RDY_up_check),
    .EN_up_check(EN_up_check),
    .out_data(out_data),
    .RDY_out(RDY_out),
    .EN_out(EN_out),
    .match_count(match_count),
    .mismatch_count(mismatch_count),
    .err(err)
  );

  task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    fifoQ.delete();
    mCnt    = 0;
    mmCnt   = 0;
    errM    = 1'b0;
    pending = 1'b0;
    halted  = 1'b0;
  endtask

  task automatic applyStimulus(input bit rst, input bit rr, input bit rc,
                               input logic [WIDTH-1:0] res, input logic [WIDTH-1:0] chk, input bit eo);
    RST           = rst;
    RDY_up_result = rr;
    RDY_up_check  = rc;
    up_result     = res;
    up_chresult   = chk;
    EN_out        = eo;
  endtask

  // Compare mid-cycle against the model, then advance the model across the coming edge.
  task automatic checkOutput();
    bit take;
    #4;
    take = !pending && !halted && RDY_up_result && RDY_up_check && (fifoQ.size() < DEPTH);
    checkValue("en_up_check", 32'(EN_up_check), 32'(take));
    checkValue("rdy_out", 32'(RDY_out), 32'(fifoQ.size() != 0));
    if (fifoQ.size() != 0)
      checkValue("out_data", 32'(out_data), 32'(fifoQ[0]));
    checkValue("match_count", 32'(match_count), 32'(mCnt));
    checkValue("mismatch_count", 32'(mismatch_count), 32'(mmCnt));
    checkValue("err", 32'(err), 32'(errM));
    lastTake = take;
    if (EN_up_check === 1'b1)
      takes++;
    if (RST) begin
      modelReset();
    end else begin
      if (EN_out && fifoQ.size() != 0)
        void'(fifoQ.pop_front());
      if (pending) begin
        if (pendRes == pendChk) begin
          mCnt = (mCnt < 255) ? mCnt + 1 : 255;
        end else begin
          mmCnt = (mmCnt < 255) ? mmCnt + 1 : 255;
          errM  = 1'b1;
`ifdef DESIGN_07_RESULT_DRAIN_HALT_ON_ERR_EN
          halted = 1'b1;
`endif
        end
        fifoQ.push_back(pendRes);
        pending = 1'b0;
      end
      if (take) begin
        pending = 1'b1;
        pendRes = up_result;
        pendChk = up_chresult;
      end
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic step(input bit rst, input bit rr, input bit rc,
                      input logic [WIDTH-1:0] res, input logic [WIDTH-1:0] chk, input bit eo);
    applyStimulus(rst, rr, rc, res, chk, eo);
    checkOutput();
  endtask

  initial begin
    int t0;
    int val;
    int n;
    int cyc;
    logic [WIDTH-1:0] v;
    logic [WIDTH-1:0] a;

    applyStimulus(1'b1, 1'b0, 1'b0, '0, '0, 1'b0);
    modelReset();
    takes = 0;
    repeat (2) @(posedge CLK);
    #1;

    $display("[TB] reset and idle");
    step(1'b1, 1'b0, 1'b0, '0, '0, 1'b0);
    repeat (10) step(1'b0, 1'b0, 1'b0, '0, '0, 1'b0);

    $display("[TB] single match");
    t0 = takes;
    step(1'b0, 1'b1, 1'b1, 11'h2A5, 11'h2A5, 1'b0);
    repeat (3) step(1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
    checkValue("single_take_pulses", 32'(takes - t0), 32'd1);
    checkValue("single_out_data", 32'(out_data), 32'h2A5);
    step(1'b0, 1'b0, 1'b0, '0, '0, 1'b1);

    $display("[TB] fill fifo");
    t0  = takes;
    val = 1;
    for (int i = 0; i < 10; i++) begin
      step(1'b0, val <= 6, val <= 6, WIDTH'(val), WIDTH'(val), 1'b0);
      if (lastTake) val++;
    end
    checkValue("full_takes", 32'(takes - t0), 32'd4);
    for (int k = 0; k < 4; k++) begin
      checkValue("pop_order", 32'(out_data), 32'(k + 1));
      step(1'b0, val <= 6, val <= 6, WIDTH'(val), WIDTH'(val), 1'b1);
      if (lastTake) val++;
      step(1'b0, val <= 6, val <= 6, WIDTH'(val), WIDTH'(val), 1'b0);
      if (lastTake) val++;
    end
    repeat (6) step(1'b0, 1'b0, 1'b0, '0, '0, 1'b1);

    $display("[TB] mismatch");
    step(1'b0, 1'b1, 1'b1, 11'h7FF, 11'h000, 1'b0);
    repeat (2) step(1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 11'h123, 11'h123, 1'b0);
    repeat (3) step(1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
    repeat (4) step(1'b0, 1'b0, 1'b0, '0, '0, 1'b1);
    step(1'b1, 1'b0, 1'b0, '0, '0, 1'b0);

    $display("[TB] saturation");
    n   = 0;
    cyc = 0;
    while (n < 300 && cyc < 1000) begin
      v = WIDTH'($urandom);
      step(1'b0, 1'b1, 1'b1, v, v, 1'b1);
      if (lastTake) n++;
      cyc++;
    end
    checkValue("sat_takes", 32'(n), 32'd300);
    repeat (2) step(1'b0, 1'b0, 1'b0, '0, '0, 1'b1);
    checkValue("match_saturated", 32'(match_count), 32'hFF);

    $display("[TB] simultaneous push and pop");
    step(1'b1, 1'b0, 1'b0, '0, '0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 11'h011, 11'h011, 1'b0);
    step(1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 11'h022, 11'h022, 1'b0);
    step(1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 11'h033, 11'h033, 1'b0);
    step(1'b0, 1'b0, 1'b0, '0, '0, 1'b1);
    checkValue("pp_head", 32'(out_data), 32'h022);
    checkValue("pp_count", 32'(fifoQ.size()), 32'd2);
    repeat (3) step(1'b0, 1'b0, 1'b0, '0, '0, 1'b1);

    $display("[TB] reset during compare");
    step(1'b0, 1'b1, 1'b1, 11'h044, 11'h044, 1'b0);
    step(1'b1, 1'b0, 1'b0, '0, '0, 1'b0);
    repeat (2) step(1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
    checkValue("rst_cmp_match", 32'(match_count), 32'd0);
    checkValue("rst_cmp_rdy_out", 32'(RDY_out), 32'd0);

    $display("[TB] random traffic");
    for (int i = 0; i < 300; i++) begin
      a = WIDTH'($urandom);
      v = ($urandom_range(3) == 0) ? WIDTH'($urandom) : a;
      step(($urandom_range(99) == 0), ($urandom_range(3) != 0), ($urandom_range(3) != 0),
           a, v, $urandom_range(1));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
